// File: rtl/itu_656_encoder.sv
// itu_656_encoder: 525-line BT.656 byte-stream generator.
// Free-running line/byte counters insert EAV/SAV codes and blanking fill, and pull
// 4:2:2 pixels through a request strobe whose data is sampled two cycles later.
// Optional 75% colour-bar generator is built when ITU656_COLORBAR_EN is defined.
module itu_656_encoder #(
    parameter int H_BLANK  = 268,
    parameter int H_ACTIVE = 1440,
    parameter int V_TOTAL  = 525
) (
    input  logic        iCLK_27,
    input  logic        iRST,
    input  logic [15:0] iYCbCr,
    input  logic        iPattern,
    output logic [7:0]  oTD_DATA,
    output logic        oREQ,
    output logic [9:0]  oTV_X,
    output logic [9:0]  oTV_Y,
    output logic        oField,
    output logic        oSOF
);
    localparam int            H_TOTAL = 8 + H_BLANK + H_ACTIVE;
    localparam int            PW      = $clog2(H_TOTAL);
    localparam logic [PW-1:0] SAV_P   = PW'(4 + H_BLANK);
    localparam logic [PW-1:0] ACT_P   = PW'(8 + H_BLANK);
    // First request leads the first active byte by two positions (inside SAV).
    localparam logic [PW-1:0] REQ_LO  = PW'(6 + H_BLANK);
    localparam logic [PW-1:0] REQ_HI  = PW'(H_TOTAL - 4);
    localparam logic [PW-1:0] P_LAST  = PW'(H_TOTAL - 1);
    localparam logic [9:0]    L_LAST  = 10'(V_TOTAL);

    logic [PW-1:0] p;          // position of the byte computed on the next edge
    logic [9:0]    line;
    logic [7:0]    hold_y;     // Y half of the last sampled pixel
    logic          bar_mode;

    logic          f, v;
    logic [PW-1:0] a, s;
    logic [9:0]    n;
    logic          load_hold;
    logic [7:0]    byte_nxt;
    logic          req_nxt;
    logic [9:0]    x_nxt;

    function automatic logic [7:0] xy(input logic ff, input logic vv, input logic hh);
        return {1'b1, ff, vv, hh, vv ^ hh, ff ^ hh, ff ^ vv, ff ^ vv ^ hh};
    endfunction

    // Byte idx of a 4-byte timing reference: FF 00 00 XY.
    function automatic logic [7:0] tc_byte(input logic [1:0] idx, input logic [7:0] last);
        case (idx)
            2'd0:    return 8'hFF;
            2'd3:    return last;
            default: return 8'h00;
        endcase
    endfunction

    // Pixel data may never alias a timing-reference byte.
    function automatic logic [7:0] clip(input logic [7:0] d);
        if (d == 8'h00) return 8'h01;
        if (d == 8'hFF) return 8'hFE;
        return d;
    endfunction

`ifdef ITU656_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 16;

    // 75% BT.601 bars: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [7:0] bar_byte(input logic [9:0] px, input logic y_sel);
        logic [2:0] b;
        logic [7:0] yv, cb, cr;
        b = 3'd0;
        for (int i = 1; i < 8; i++)
            if (px >= 10'(i * BAR_W)) b = 3'(i);
        case (b)
            3'd0:    {yv, cb, cr} = {8'hB4, 8'h80, 8'h80};
            3'd1:    {yv, cb, cr} = {8'hA2, 8'h2C, 8'h8E};
            3'd2:    {yv, cb, cr} = {8'h83, 8'h9C, 8'h2C};
            3'd3:    {yv, cb, cr} = {8'h70, 8'h48, 8'h3A};
            3'd4:    {yv, cb, cr} = {8'h54, 8'hB8, 8'hC6};
            3'd5:    {yv, cb, cr} = {8'h41, 8'h64, 8'hD4};
            3'd6:    {yv, cb, cr} = {8'h23, 8'hD4, 8'h72};
            default: {yv, cb, cr} = {8'h10, 8'h80, 8'h80};
        endcase
        return y_sel ? yv : (px[0] ? cr : cb);
    endfunction

    // Pattern select is latched at the start of each line so a line is never torn.
    always_ff @(posedge iCLK_27 or posedge iRST) begin
        if (iRST)         bar_mode <= 1'b0;
        else if (p == '0) bar_mode <= iPattern;
    end
`else
    logic unused_pattern;
    assign bar_mode       = 1'b0;
    assign unused_pattern = iPattern;
`endif

    // Field and vertical-blanking flags of the current line.
    always_comb begin
        f = 1'b1;
        v = 1'b1;
        if      (line <= 10'd3)   begin f = 1'b1; v = 1'b1; end
        else if (line <= 10'd19)  begin f = 1'b0; v = 1'b1; end
        else if (line <= 10'd263) begin f = 1'b0; v = 1'b0; end
        else if (line <= 10'd265) begin f = 1'b0; v = 1'b1; end
        else if (line <= 10'd282) begin f = 1'b1; v = 1'b1; end
        else                      begin f = 1'b1; v = 1'b0; end
    end

    // Next output byte, request strobe and pixel index for position p.
    always_comb begin
        a         = p - ACT_P;
        s         = p - SAV_P;
        n         = 10'(a >> 1);
        load_hold = 1'b0;
        x_nxt     = (p >= ACT_P) ? n : 10'd0;
        req_nxt   = !v && !bar_mode && (p >= REQ_LO) && (p <= REQ_HI) && !a[0];
        byte_nxt  = 8'h80;
        if (p < PW'(4))     byte_nxt = tc_byte(p[1:0], xy(f, v, 1'b1));
        else if (p < SAV_P) byte_nxt = p[0] ? 8'h10 : 8'h80;
        else if (p < ACT_P) byte_nxt = tc_byte(s[1:0], xy(f, v, 1'b0));
        else if (v)         byte_nxt = a[0] ? 8'h10 : 8'h80;
`ifdef ITU656_COLORBAR_EN
        else if (bar_mode)  byte_nxt = bar_byte(n, a[0]);
`endif
        else if (!a[0]) begin
            // Requested pixel is on the bus now: emit C and keep Y for next byte.
            byte_nxt  = clip(iYCbCr[7:0]);
            load_hold = 1'b1;
        end
        else                byte_nxt = clip(hold_y);
    end

    // Byte/line counters, registered outputs and pixel hold.
    always_ff @(posedge iCLK_27 or posedge iRST) begin
        if (iRST) begin
            p        <= '0;
            line     <= 10'd1;
            hold_y   <= 8'h00;
            oTD_DATA <= 8'h80;
            oREQ     <= 1'b0;
            oTV_X    <= 10'd0;
            oTV_Y    <= 10'd1;
            oField   <= 1'b1;
            oSOF     <= 1'b0;
        end else begin
            oTD_DATA <= byte_nxt;
            oREQ     <= req_nxt;
            oTV_X    <= x_nxt;
            oSOF     <= (p == '0) && (line == 10'd1);
            if (p == '0) begin
                oTV_Y  <= line;
                oField <= f;
            end
            if (load_hold) hold_y <= iYCbCr[15:8];
            if (p == P_LAST) begin
                p    <= '0;
                line <= (line == L_LAST) ? 10'd1 : line + 10'd1;
            end else begin
                p <= p + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_itu_656_encoder.sv
// tb_itu_656_encoder: reduced-width encoder checked byte-for-byte against a
// cycle-count model over a full frame, plus a full-width encoder over two lines.
module tb_itu_656_encoder;
    localparam int HB  = 8;
    localparam int HA  = 32;
    localparam int HT  = 8 + HB + HA;
    localparam int FR  = 525 * HT;
    localparam int HBF = 268;
    localparam int HAF = 1440;
    localparam int HTF = 8 + HBF + HAF;

    localparam logic [7:0] BY  [8] = '{8'hB4, 8'hA2, 8'h83, 8'h70, 8'h54, 8'h41, 8'h23, 8'h10};
    localparam logic [7:0] BCB [8] = '{8'h80, 8'h2C, 8'h9C, 8'h48, 8'hB8, 8'h64, 8'hD4, 8'h80};
    localparam logic [7:0] BCR [8] = '{8'h80, 8'h8E, 8'h2C, 8'h3A, 8'hC6, 8'hD4, 8'h72, 8'h80};

    typedef struct packed {
        logic [7:0] b;
        logic       req;
        logic [9:0] x;
        logic [9:0] y;
        logic       fld;
        logic       sof;
    } out_t;

    typedef struct {
        int         line;
        int         p;
        logic [7:0] exp;
    } vec_t;

    localparam out_t RST_V = {8'h80, 1'b0, 10'd0, 10'd1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ycc = 16'h0;
    logic        pat = 1'b0;
    logic [7:0]  td, tdf;
    logic        req, reqf, fld, fldf, sof, soff;
    logic [9:0]  tx, ty, txf, tyf;

    itu_656_encoder #(.H_BLANK(HB), .H_ACTIVE(HA), .V_TOTAL(525)) dut (
        .iCLK_27(clk), .iRST(rst), .iYCbCr(ycc), .iPattern(pat),
        .oTD_DATA(td), .oREQ(req), .oTV_X(tx), .oTV_Y(ty), .oField(fld), .oSOF(sof));

    itu_656_encoder dut_f (
        .iCLK_27(clk), .iRST(rst), .iYCbCr(ycc), .iPattern(pat),
        .oTD_DATA(tdf), .oREQ(reqf), .oTV_X(txf), .oTV_Y(tyf), .oField(fldf), .oSOF(soff));

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         salt;
    bit         bars;
    int         c;
    int         nreq, nreq20;
    int         sof_q [$];
    int         bad  [2];
    int         seen [2];
    out_t       fa   [2];
    out_t       fe   [2];
    logic [7:0] cap  [0:525][0:HT-1];

    // F=1 on lines 1-3 and 266-525; V=1 on lines 1-19 and 264-282.
    function automatic int fbit(int l);
        return ((l <= 3) || (l >= 266)) ? 1 : 0;
    endfunction
    function automatic int vbit(int l);
        return ((l <= 19) || (l >= 264 && l <= 282)) ? 1 : 0;
    endfunction
    function automatic logic [7:0] xyb(int l, int h);
        int f, v;
        f = fbit(l);
        v = vbit(l);
        return 8'(128 + 64*f + 32*v + 16*h + 8*(v^h) + 4*(f^h) + 2*(f^v) + (f^v^h));
    endfunction
    function automatic logic [7:0] lim(logic [7:0] d);
        return (d == 8'h00) ? 8'h01 : (d == 8'hFF) ? 8'hFE : d;
    endfunction

    // Source pixels: ramp on line 20, saturated on 21-25, hashed elsewhere.
    function automatic logic [15:0] src(int l, int n);
        if (l == 20) return {8'(n), 8'(128 + n % 2)};
        if (l >= 21 && l <= 25) return 16'hFF00;
        return 16'(salt + n * 40503 + l * 977);
    endfunction

    // Expected outputs for cycle c after reset release.
    function automatic out_t model(int cc, int hb, int ha, bit bar);
        int ht, l, p, act, a, n, bi;
        logic [15:0] pix;
        out_t o;
        ht  = 8 + hb + ha;
        l   = (cc / ht) % 525 + 1;
        p   = cc % ht;
        act = 8 + hb;
        a   = p - act;
        n   = a / 2;
        o.y   = 10'(l);
        o.fld = fbit(l) != 0;
        o.sof = (p == 0 && l == 1);
        o.req = 1'b0;
        o.x   = 10'd0;
        if (p < 4)             o.b = (p == 0) ? 8'hFF : (p == 3) ? xyb(l, 1) : 8'h00;
        else if (p < act - 4)  o.b = ((p - 4) % 2 != 0) ? 8'h10 : 8'h80;
        else if (p < act)      o.b = (p == act - 4) ? 8'hFF : (p == act - 1) ? xyb(l, 0) : 8'h00;
        else begin
            o.x = 10'(n);
            if (vbit(l) != 0) o.b = (a % 2 != 0) ? 8'h10 : 8'h80;
            else if (bar) begin
                bi  = n / (ha / 16);
                o.b = (a % 2 != 0) ? BY[bi] : ((n % 2 != 0) ? BCR[bi] : BCB[bi]);
            end else begin
                pix = src(l, n);
                o.b = (a % 2 != 0) ? lim(pix[15:8]) : lim(pix[7:0]);
            end
        end
        if (vbit(l) == 0 && !bar && p >= act - 2 && p <= act + ha - 4 && (p - act) % 2 == 0)
            o.req = 1'b1;
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic acc(int d, out_t a, out_t e);
        seen[d]++;
        if (a !== e) begin
            if (bad[d] == 0) begin fa[d] = a; fe[d] = e; end
            bad[d]++;
        end
    endtask

    // One comparison per line (or partial line) of the stream.
    task automatic flush(int d, int l);
        if (seen[d] == 0) return;
        tests++;
        if (bad[d] != 0) begin
            fails++;
            $display("FAIL stream %s line %0d: %0d of %0d cycles wrong, first {byte,req,x,y,f,sof} got %h expected %h",
                     (d == 0) ? "dut" : "dut_f", l, bad[d], seen[d], fa[d], fe[d]);
        end
        bad[d]  = 0;
        seen[d] = 0;
    endtask

    task automatic run(int ncyc, bit full);
        for (int k = 0; k < ncyc; k++) begin
            int l, p;
            l = (c / HT) % 525 + 1;
            p = c % HT;
            if (!bars && vbit(l) == 0 && p >= HB + 7 && p <= HT - 3 && (p - HB - 7) % 2 == 0)
                ycc = src(l, (p - HB - 7) / 2);
            else
                ycc = 16'($urandom);
`ifndef ITU656_COLORBAR_EN
            pat = 1'($urandom);
`endif
            acc(0, {td, req, tx, ty, fld, sof}, model(c, HB, HA, bars));
            if (p == HT - 1) flush(0, l);
            if (full && c < 2 * HTF) begin
                acc(1, {tdf, reqf, txf, tyf, fldf, soff}, model(c, HBF, HAF, 1'b0));
                if (c % HTF == HTF - 1) flush(1, c / HTF + 1);
            end
            if (c < FR) begin
                cap[l][p] = td;
                if (req) begin
                    nreq++;
                    if (l == 20) nreq20++;
                end
            end
            if (sof) sof_q.push_back(c);
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic do_reset(int ncyc, bit immediate);
        flush(0, (c / HT) % 525 + 1);
        flush(1, c / HTF + 1);
        rst = 1'b1;
        #1;
        if (immediate) chk("reset immediate", 32'({td, req, tx, ty, fld, sof}), 32'(RST_V));
        repeat (ncyc) @(posedge clk);
        #1;
        chk("reset held dut",   32'({td, req, tx, ty, fld, sof}),       32'(RST_V));
        chk("reset held dut_f", 32'({tdf, reqf, txf, tyf, fldf, soff}), 32'(RST_V));
        rst = 1'b0;
        @(posedge clk);
        #1;
        c = 0;
    endtask

    initial begin
        vec_t tbl  [29];
        vec_t btbl [6];
        tbl = '{
            '{1, 0, 8'hFF}, '{1, 1, 8'h00}, '{1, 2, 8'h00}, '{1, 3, 8'hF1},
            '{1, 4, 8'h80}, '{1, 5, 8'h10},
            '{1, 12, 8'hFF}, '{1, 13, 8'h00}, '{1, 14, 8'h00}, '{1, 15, 8'hEC},
            '{10, 3, 8'hB6}, '{10, 15, 8'hAB}, '{20, 3, 8'h9D}, '{20, 15, 8'h80},
            '{270, 3, 8'hF1}, '{270, 15, 8'hEC}, '{300, 3, 8'hDA}, '{300, 15, 8'hC7},
            '{264, 3, 8'hB6}, '{266, 3, 8'hF1},
            '{5, 16, 8'h80}, '{5, 17, 8'h10},
            '{20, 16, 8'h80}, '{20, 17, 8'h01}, '{20, 18, 8'h81}, '{20, 19, 8'h01},
            '{21, 16, 8'h01}, '{21, 17, 8'hFE}, '{21, 11, 8'h10}};
        btbl = '{
            '{20, 16, 8'h80}, '{20, 17, 8'hB4}, '{20, 20, 8'h2C},
            '{20, 21, 8'hA2}, '{20, 46, 8'h80}, '{20, 47, 8'h10}};

        salt   = int'($urandom);
        bars   = 1'b0;
        c      = 0;
        nreq   = 0;
        nreq20 = 0;
        for (int d = 0; d < 2; d++) begin bad[d] = 0; seen[d] = 0; end

        // Power-on reset, then one full frame plus a few lines.
        do_reset(3, 1'b0);
        run(FR + 3 * HT, 1'b1);
        chk("oREQ pulses per frame", nreq, 487 * HA / 2);
        chk("oREQ pulses line 20", nreq20, HA / 2);
        chk("oSOF pulse count", sof_q.size(), 2);
        if (sof_q.size() >= 2) begin
            chk("oSOF first cycle", sof_q[0], 0);
            chk("oSOF period", sof_q[1] - sof_q[0], FR);
        end
        for (int i = 0; i < 29; i++)
            chk($sformatf("byte line %0d P%0d", tbl[i].line, tbl[i].p),
                32'(cap[tbl[i].line][tbl[i].p]), 32'(tbl[i].exp));

        // Abort mid-pixel on line 150, A=10, then restart cleanly.
        run(FR + 149 * HT + HB + 8 + 10 - c, 1'b0);
        do_reset(3, 1'b1);
        run(2 * HT, 1'b0);

`ifdef ITU656_COLORBAR_EN
        bars = 1'b1;
        pat  = 1'b1;
        do_reset(3, 1'b0);
        run(20 * HT, 1'b0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bar byte line %0d P%0d", btbl[i].line, btbl[i].p),
                32'(cap[btbl[i].line][btbl[i].p]), 32'(btbl[i].exp));
`endif
        flush(0, (c / HT) % 525 + 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
